// File: rtl/phase_a_host.sv
// phase_a_host
//   Streams a wide operand into phase_a one word at a time, least-significant
//   word first. It then fires a single start pulse and waits a bounded time for
//   the result strobe. The captured result is streamed back out with the same
//   word ordering.
//
// Ports
//   clk, rst_n                  clock, asynchronous active-low reset
//   in_data/in_valid/in_ready   operand word stream (accepted only in LOAD)
//   pa_a, pa_en                 assembled operand and start pulse to phase_a
//   pa_new_a, pa_done           result and result strobe from phase_a
//   out_data/out_valid/out_ready result word stream (driven only in UNLOAD)
//   busy                        high whenever the FSM is not in LOAD
//   timeout_err                 sticky: phase_a did not answer in time
//
// state  | meaning
// -------+-----------------------------------------------------------
// LOAD   | accept NWORDS operand words into pa_a
// ISSUE  | one-cycle pa_en pulse, timeout counter cleared
// WAIT   | wait for pa_done (captured) or TIMEOUT expiry (discarded)
// UNLOAD | present result words on out_data until all are taken
module phase_a_host #(
    parameter int WORD_W  = 64,
    parameter int OP_W    = 3072,
    parameter int TIMEOUT = 255
) (
    input  logic              clk,
    input  logic              rst_n,
    input  logic [WORD_W-1:0] in_data,
    input  logic              in_valid,
    output logic              in_ready,
    output logic [OP_W-1:0]   pa_a,
    output logic              pa_en,
    input  logic [OP_W-1:0]   pa_new_a,
    input  logic              pa_done,
    output logic [WORD_W-1:0] out_data,
    output logic              out_valid,
    input  logic              out_ready,
    output logic              busy,
    output logic              timeout_err
);

    localparam int NWORDS = OP_W / WORD_W;
    localparam int KW     = (NWORDS > 1) ? $clog2(NWORDS) : 1;
    localparam int TW     = (TIMEOUT > 0) ? $clog2(TIMEOUT + 1) : 1;
    localparam logic [KW-1:0] K_LAST = KW'(NWORDS - 1);
    localparam logic [TW-1:0] T_LAST = TW'(TIMEOUT);

    typedef enum logic [1:0] {
        S_LOAD,
        S_ISSUE,
        S_WAIT,
        S_UNLOAD
    } state_t;

    state_t          r_state;
    state_t          w_next;
    logic            r_live;
    logic [KW-1:0]   r_k;
    logic [TW-1:0]   r_tcnt;
    logic [OP_W-1:0] r_res;
    logic            r_err;
    logic            w_in_xfer;
    logic            w_out_xfer;
    logic            w_last_k;

    // r_live keeps in_ready low until the first edge after reset release.
    assign w_in_xfer   = (r_state == S_LOAD) && r_live && in_valid;
    assign w_out_xfer  = (r_state == S_UNLOAD) && out_ready;
    assign w_last_k    = (r_k == K_LAST);
    assign out_data    = r_res[r_k*WORD_W +: WORD_W];
    assign timeout_err = r_err;

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            r_state <= S_LOAD;
        end else begin
            r_state <= w_next;
        end
    end

    always_comb begin
        w_next    = r_state;
        in_ready  = 1'b0;
        pa_en     = 1'b0;
        out_valid = 1'b0;
        busy      = 1'b1;
        case (r_state)
            S_LOAD: begin
                in_ready = r_live;
                busy     = 1'b0;
                if (w_in_xfer && w_last_k) begin
                    w_next = S_ISSUE;
                end
            end
            S_ISSUE: begin
                pa_en  = 1'b1;
                w_next = S_WAIT;
            end
            S_WAIT: begin
                // A strobe on the final allowed cycle still counts as success.
                if (pa_done) begin
                    w_next = S_UNLOAD;
                end else if (r_tcnt == T_LAST) begin
                    w_next = S_LOAD;
                end
            end
            S_UNLOAD: begin
                out_valid = 1'b1;
                if (w_out_xfer && w_last_k) begin
                    w_next = S_LOAD;
                end
            end
            default: w_next = S_LOAD;
        endcase
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            r_live <= 1'b0;
            r_k    <= '0;
            r_tcnt <= '0;
            r_res  <= '0;
            r_err  <= 1'b0;
            pa_a   <= '0;
        end else begin
            r_live <= 1'b1;
            if (w_in_xfer) begin
                pa_a[r_k*WORD_W +: WORD_W] <= in_data;
            end
            if (w_in_xfer || w_out_xfer) begin
                r_k <= w_last_k ? '0 : r_k + 1'b1;
            end
            if (r_state == S_ISSUE) begin
                r_tcnt <= '0;
            end
            if (r_state == S_WAIT) begin
                if (pa_done) begin
                    r_res <= pa_new_a;
                end else if (r_tcnt == T_LAST) begin
                    r_err <= 1'b1;
                end else begin
                    r_tcnt <= r_tcnt + 1'b1;
                end
            end
        end
    end

endmodule

// File: tb/tb_phase_a_host.sv
// Directed bench for phase_a_host at default parameters (64-bit words,
// 48-word operand, 255-cycle timeout).
module tb_phase_a_host;

    localparam int WORD_W = 64;
    localparam int OP_W   = 3072;
    localparam int NW     = 48;
    localparam int TMO    = 255;

    logic              clk = 1'b0;
    logic              rst_n = 1'b0;
    logic [WORD_W-1:0] in_data = '0;
    logic              in_valid = 1'b0;
    logic              in_ready;
    logic [OP_W-1:0]   pa_a;
    logic              pa_en;
    logic [OP_W-1:0]   pa_new_a = '0;
    logic              pa_done = 1'b0;
    logic [WORD_W-1:0] out_data;
    logic              out_valid;
    logic              out_ready = 1'b0;
    logic              busy;
    logic              timeout_err;

    int n_checks = 0;
    int n_errors = 0;
    logic seen_ov;

    phase_a_host #(.WORD_W(WORD_W), .OP_W(OP_W), .TIMEOUT(TMO)) dut (
        .clk(clk), .rst_n(rst_n),
        .in_data(in_data), .in_valid(in_valid), .in_ready(in_ready),
        .pa_a(pa_a), .pa_en(pa_en),
        .pa_new_a(pa_new_a), .pa_done(pa_done),
        .out_data(out_data), .out_valid(out_valid), .out_ready(out_ready),
        .busy(busy), .timeout_err(timeout_err)
    );

    always #5 clk = ~clk;

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    task automatic chk(input string tag, input logic [63:0] obs, input logic [63:0] exp);
        n_checks++;
        assert (obs === exp) else begin
            n_errors++;
            $error("FAIL %s: observed %0h expected %0h", tag, obs, exp);
        end
    endtask

    task automatic load_words(input logic [63:0] base, input int n);
        in_valid = 1'b1;
        for (int i = 0; i < n; i++) begin
            in_data = base + 64'(i);
            chk("in_ready_load", 64'(in_ready), 64'd1);
            tick();
        end
        in_valid = 1'b0;
    endtask

    // Called in the cycle right after the last input handshake.
    task automatic issue_check();
        chk("pa_en_issue", 64'(pa_en), 64'd1);
        chk("in_ready_issue", 64'(in_ready), 64'd0);
        chk("busy_issue", 64'(busy), 64'd1);
        tick();
        chk("pa_en_single", 64'(pa_en), 64'd0);
    endtask

    task automatic set_result(input logic [63:0] base);
        for (int i = 0; i < NW; i++) begin
            pa_new_a[i*WORD_W +: WORD_W] = base + 64'(i);
        end
    endtask

    // Starts in the first WAIT cycle; strobes pa_done `cyc` cycles after pa_en.
    task automatic answer_after(input int cyc);
        repeat (cyc - 1) tick();
        pa_done = 1'b1;
        tick();
        pa_done = 1'b0;
        chk("out_valid_first", 64'(out_valid), 64'd1);
    endtask

    task automatic unload(input logic [63:0] base, input int n, input bit toggle);
        for (int i = 0; i < n; i++) begin
            if (toggle) begin
                out_ready = 1'b0;
                chk("out_data_pre", out_data, base + 64'(i));
                tick();
                chk("out_valid_stall", 64'(out_valid), 64'd1);
                chk("out_data_stall", out_data, base + 64'(i));
            end
            out_ready = 1'b1;
            chk("out_valid", 64'(out_valid), 64'd1);
            chk("out_data", out_data, base + 64'(i));
            if (i < n - 1 || n == NW) tick();
        end
    endtask

    task automatic unload_done();
        out_ready = 1'b0;
        chk("out_valid_end", 64'(out_valid), 64'd0);
        chk("in_ready_end", 64'(in_ready), 64'd1);
        chk("busy_end", 64'(busy), 64'd0);
    endtask

    initial begin
        // reset values while held
        #1;
        chk("rst_in_ready", 64'(in_ready), 64'd0);
        chk("rst_busy", 64'(busy), 64'd0);
        chk("rst_pa_en", 64'(pa_en), 64'd0);
        chk("rst_out_valid", 64'(out_valid), 64'd0);
        chk("rst_timeout_err", 64'(timeout_err), 64'd0);
        chk("rst_pa_a", pa_a[63:0], 64'd0);
        tick();
        chk("rst_in_ready_held", 64'(in_ready), 64'd0);
        #2 rst_n = 1'b1;
        #1 chk("in_ready_before_edge", 64'(in_ready), 64'd0);
        tick();
        chk("in_ready_after_release", 64'(in_ready), 64'd1);

        // op 1: continuous load, answer after 10 cycles, in_valid held in WAIT
        load_words(64'd1, NW);
        chk("pa_a_lo", pa_a[63:0], 64'd1);
        chk("pa_a_hi", pa_a[OP_W-1 -: 64], 64'd48);
        issue_check();
        in_valid = 1'b1;
        in_data  = 64'hDEAD;
        chk("in_ready_wait", 64'(in_ready), 64'd0);
        set_result(64'hA000);
        answer_after(10);
        in_valid = 1'b0;
        chk("pa_a_lo_after_wait", pa_a[63:0], 64'd1);
        chk("pa_a_w1_after_wait", pa_a[127:64], 64'd2);
        unload(64'hA000, NW, 1'b0);
        unload_done();

        // pa_done pulse while in LOAD is ignored
        pa_new_a = '1;
        pa_done  = 1'b1;
        tick();
        pa_done = 1'b0;
        chk("load_done_busy", 64'(busy), 64'd0);
        chk("load_done_out_valid", 64'(out_valid), 64'd0);
        chk("load_done_in_ready", 64'(in_ready), 64'd1);

        // op 2: out_ready toggling
        load_words(64'h100, NW);
        chk("op2_pa_a_hi", pa_a[OP_W-1 -: 64], 64'h12F);
        issue_check();
        set_result(64'hC000);
        answer_after(10);
        unload(64'hC000, NW, 1'b1);
        unload_done();

        // op 3: no answer -> timeout
        load_words(64'h200, NW);
        issue_check();
        seen_ov = 1'b0;
        repeat (TMO) begin
            tick();
            seen_ov = seen_ov | out_valid;
        end
        chk("tmo_not_yet", 64'(timeout_err), 64'd0);
        chk("tmo_busy_last", 64'(busy), 64'd1);
        chk("tmo_no_out_valid", 64'(seen_ov), 64'd0);
        tick();
        chk("tmo_err_set", 64'(timeout_err), 64'd1);
        chk("tmo_in_ready", 64'(in_ready), 64'd1);
        chk("tmo_busy", 64'(busy), 64'd0);

        // op 4: answer on the last allowed WAIT cycle wins
        load_words(64'h300, NW);
        issue_check();
        set_result(64'hD000);
        answer_after(TMO + 1);
        chk("edge_err_sticky", 64'(timeout_err), 64'd1);
        unload(64'hD000, NW, 1'b0);
        unload_done();
        chk("err_still_set", 64'(timeout_err), 64'd1);

        // reset at word 20 of LOAD
        load_words(64'h400, 20);
        in_valid = 1'b1;
        in_data  = 64'h414;
        rst_n    = 1'b0;
        #1;
        chk("mid_rst_in_ready", 64'(in_ready), 64'd0);
        chk("mid_rst_err", 64'(timeout_err), 64'd0);
        chk("mid_rst_pa_a", pa_a[63:0], 64'd0);
        chk("mid_rst_pa_a_w19", pa_a[19*64 +: 64], 64'd0);
        in_valid = 1'b0;
        #2 rst_n = 1'b1;
        tick();
        load_words(64'd1, NW);
        chk("rl_pa_a_lo", pa_a[63:0], 64'd1);
        chk("rl_pa_a_hi", pa_a[OP_W-1 -: 64], 64'd48);
        issue_check();
        set_result(64'hA000);
        answer_after(10);
        unload(64'hA000, 5, 1'b0);

        // reset during UNLOAD word 5
        rst_n = 1'b0;
        #1;
        chk("un_rst_out_valid", 64'(out_valid), 64'd0);
        chk("un_rst_busy", 64'(busy), 64'd0);
        chk("un_rst_out_data", out_data, 64'd0);
        chk("un_rst_pa_a", pa_a[OP_W-1 -: 64], 64'd0);
        out_ready = 1'b0;
        #2 rst_n = 1'b1;
        tick();
        load_words(64'd1, NW);
        chk("r2_pa_a_lo", pa_a[63:0], 64'd1);
        chk("r2_pa_a_hi", pa_a[OP_W-1 -: 64], 64'd48);
        issue_check();
        set_result(64'hA000);
        answer_after(10);
        unload(64'hA000, NW, 1'b0);
        unload_done();

        $display("Simulation finished: %0d checks, %0d errors", n_checks, n_errors);
        $finish;
    end

endmodule

// File: doc/phase_a_host.md
PHASE_A_HOST -- requirements
Module: phase_a_host

Interface
REQ-001 SHALL have parameter WORD_W, default 64, stream word width in bits.
REQ-002 SHALL have parameter OP_W, default 3072, operand width; OP_W/WORD_W = NWORDS (48 at defaults).
REQ-003 SHALL have parameter TIMEOUT, default 255, max cycles waited for pa_done after issue.
REQ-004 SHALL have port clk  input  1  sole clock, rising edge.
REQ-005 SHALL have port rst_n  input  1  reset, asynchronous, active-low.
REQ-006 SHALL have port in_data  input  WORD_W  operand word, least-significant word first.
REQ-007 SHALL have port in_valid  input  1  in_data valid.
REQ-008 SHALL have port in_ready  output  1  block accepts in_data this cycle.
REQ-009 SHALL have port pa_a  output  OP_W  assembled operand driven to phase_a "a".
REQ-010 SHALL have port pa_en  output  1  single-cycle start pulse to phase_a "en".
REQ-011 SHALL have port pa_new_a  input  OP_W  result from phase_a "new_a".
REQ-012 SHALL have port pa_done  input  1  result strobe from phase_a "en_out".
REQ-013 SHALL have port out_data  output  WORD_W  result word, least-significant word first.
REQ-014 SHALL have port out_valid  output  1  out_data valid.
REQ-015 SHALL have port out_ready  input  1  downstream accepts out_data.
REQ-016 SHALL have port busy  output  1  high in every state except LOAD.
REQ-017 SHALL have port timeout_err  output  1  sticky flag: phase_a failed to answer.

Function
REQ-018 SHALL implement FSM states LOAD, ISSUE, WAIT, UNLOAD; reset state LOAD.
REQ-019 LOAD: in_ready=1; word transferred when in_valid&in_ready; word k written to pa_a[k*WORD_W +: WORD_W]; word counter k increments 0..NWORDS-1.
REQ-020 LOAD: transfer of word NWORDS-1 SHALL move FSM to ISSUE next cycle and clear k to 0.
REQ-021 ISSUE: pa_en=1 for exactly one cycle, in_ready=0; next state WAIT; timeout counter cleared to 0.
REQ-022 pa_a SHALL hold stable from ISSUE until FSM re-enters LOAD and receives a new word 0.
REQ-023 WAIT: pa_done=1 SHALL capture pa_new_a into result register same edge and move to UNLOAD.
REQ-024 WAIT: each cycle without pa_done increments timeout counter; pa_done absent after TIMEOUT cycles SHALL set timeout_err=1, discard operation, return to LOAD.
REQ-025 pa_done arriving in the same cycle the counter reaches TIMEOUT SHALL be treated as success (capture wins).
REQ-026 pa_done in LOAD, ISSUE or UNLOAD SHALL be ignored.
REQ-027 UNLOAD: out_valid=1, out_data = result[k*WORD_W +: WORD_W]; k increments only on out_valid&out_ready; out_data stable while out_ready=0.
REQ-028 UNLOAD: handshake on word NWORDS-1 SHALL return FSM to LOAD next cycle, k=0, out_valid=0.
REQ-029 Latency: first out_valid SHALL rise the cycle after the pa_done edge; pa_en SHALL rise the cycle after the last input handshake.
REQ-030 in_ready SHALL be 0 outside LOAD; in_valid outside LOAD is ignored, no data lost or latched.
REQ-031 timeout_err SHALL clear only on reset; further operations proceed normally while it is set.
REQ-032 No arithmetic on operand data; counters SHALL saturate/wrap only as stated (k 0..NWORDS-1, timeout 0..TIMEOUT).

Reset
REQ-033 rst_n low SHALL immediately (asynchronously) force state LOAD, k=0, timeout counter 0, pa_en=0, out_valid=0, timeout_err=0, pa_a=0, result register=0.
REQ-034 Reset mid-operation (any state) SHALL abandon the operation; first word after release is word 0 of a new operand.
REQ-035 in_ready SHALL read 0 while rst_n is low and 1 from the first clock edge after release.

Verification
REQ-036 Load 48 words in_data=k+1 continuously -> pa_a[63:0]=1, pa_a[3071:3008]=48, pa_en high exactly 1 cycle after word 48.
REQ-037 pa_done 10 cycles after pa_en with pa_new_a word k = 0xA000+k, out_ready=1 -> 48 consecutive out words 0xA000..0xA02F, then in_ready=1.
REQ-038 Same, out_ready toggled 1/0 every cycle -> out_data held while stalled, 48 words, no duplicates or drops.
REQ-039 No pa_done after issue -> timeout_err=1 after 255 wait cycles, out_valid never asserted, in_ready=1 next cycle; next full operation succeeds with timeout_err still 1.
REQ-040 rst_n pulsed low at word 20 of LOAD and again in UNLOAD word 5 -> all outputs at reset values immediately; next 48-word load behaves as REQ-036.
REQ-041 pa_done pulse in LOAD and in_valid held high during WAIT -> both ignored; pa_a and word counter unchanged.
